// File: rtl/line_fill_responder.sv
// Line-granular backing-store responder: fixed access latency, then LINE_WORDS-beat read or write bursts.
// Optional `CRITICAL_WORD_FIRST_EN makes refills start at the requested word and wrap within the line.
module line_fill_responder #(
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int LINE_WORDS     = 4,
  parameter int LATENCY        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [31:0]                   req_addr,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [31:0]                   wr_data,
  output logic                          wr_done,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [31:0]                   rd_data,
  output logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic                          rd_last
);

  localparam int OW    = $clog2(LINE_WORDS);
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int CW    = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(LATENCY - 1);
  localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, WDONE} state_t;

  state_t                         state;
  logic [MEM_DEPTH_LOG2-OW-1:0]   line_base;
  logic [OW-1:0]                  start_off;
  logic                           is_write;
  logic [CW-1:0]                  wait_cnt;
  logic [OW-1:0]                  beat_cnt;

  logic [31:0] mem [0:DEPTH-1];

  logic [MEM_DEPTH_LOG2-OW-1:0] req_line;
  logic [OW-1:0]                req_off;
  logic                         unused_addr_bits;

  assign req_line = req_addr[MEM_DEPTH_LOG2+1:OW+2];

`ifdef CRITICAL_WORD_FIRST_EN
  assign req_off          = req_addr[OW+1:2];
  assign unused_addr_bits = ^{req_addr[31:MEM_DEPTH_LOG2+2], req_addr[1:0]};
`else
  assign req_off          = '0;
  assign unused_addr_bits = ^{req_addr[31:MEM_DEPTH_LOG2+2], req_addr[OW+1:0]};
`endif

  logic mem_we;
  assign mem_we = (state == WBURST) && wr_valid;

  // Writes always fill the line in order, independent of the read start offset.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[{line_base, beat_cnt}] <= wr_data;
  end

  // rd_word is registered, so rd_data holds steady under backpressure.
  assign rd_data = mem[{line_base, rd_word}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      line_base <= '0;
      start_off <= '0;
      is_write  <= 1'b0;
      wait_cnt  <= '0;
      beat_cnt  <= '0;
      req_ready <= 1'b1;
      wr_ready  <= 1'b0;
      wr_done   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_word   <= '0;
      rd_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            line_base <= req_line;
            start_off <= req_write ? '0 : req_off;
            is_write  <= req_write;
            wait_cnt  <= WAIT_LOAD;
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            beat_cnt <= '0;
            if (is_write) begin
              wr_ready <= 1'b1;
              state    <= WBURST;
            end else begin
              rd_valid <= 1'b1;
              rd_word  <= start_off;
              rd_last  <= 1'b0;
              state    <= RBURST;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RBURST: begin
          if (rd_ready) begin
            if (beat_cnt == LAST_BEAT) begin
              rd_valid  <= 1'b0;
              rd_last   <= 1'b0;
              rd_word   <= '0;
              beat_cnt  <= '0;
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              rd_word  <= rd_word + 1'b1;
              rd_last  <= (beat_cnt + 1'b1) == LAST_BEAT;
            end
          end
        end
        WBURST: begin
          if (wr_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              wr_ready <= 1'b0;
              wr_done  <= 1'b1;
              state    <= WDONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WDONE: begin
          wr_done   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          wr_ready  <= 1'b0;
          wr_done   <= 1'b0;
          rd_valid  <= 1'b0;
          rd_last   <= 1'b0;
          rd_word   <= '0;
        end
      endcase
    end
  end

endmodule
